// File: rtl/serdes_drp_slave.sv
// DRP responder: 16-bit register file behind a transceiver-style DRP port with
// programmable fixed completion latency and collision / address-error flags.
module serdes_drp_slave #(
  parameter int DEPTH   = 64,
  parameter int RDY_LAT = 3
) (
  input  logic        I_drp_clk,
  input  logic        I_drp_rst_n,
  input  logic [9:0]  I_drpaddr,
  input  logic [15:0] I_drpdi,
  input  logic        I_drpwe,
  input  logic        I_drpen,
  output logic        O_drprdy,
  output logic [15:0] O_drpdo,
  output logic        O_wr_pulse,
  output logic [9:0]  O_wr_addr,
  output logic [15:0] O_wr_data,
  output logic        O_collision,
  output logic        O_addr_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, done, collide, in_range, commit;
  logic [AW-1:0] idx;
  logic [15:0] mem_q [DEPTH];
  logic [15:0] hold_q;
  logic        rdy_q, wr_pulse_q, coll_q, aerr_q;
  logic [15:0] do_q, wr_data_q;
  logic [9:0]  wr_addr_q;

  assign in_range = ({1'b0, I_drpaddr} < 11'(DEPTH));
  assign idx      = I_drpaddr[AW-1:0];
  assign commit   = accept && I_drpwe && in_range;

  always_ff @(posedge I_drp_clk or negedge I_drp_rst_n) begin
    if (!I_drp_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes seen in BUSY (including the completing edge) are dropped and flagged.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    collide = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_drpen) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = 4'(RDY_LAT - 1);
        end
      end
      BUSY: begin
        collide = I_drpen;
        if (cnt_q == 4'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_drp_clk or negedge I_drp_rst_n) begin
    if (!I_drp_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[idx] <= I_drpdi;
    end
  end

  // Holding register carries read data (0 for writes / out-of-range) to completion.
  always_ff @(posedge I_drp_clk or negedge I_drp_rst_n) begin
    if (!I_drp_rst_n) begin
      hold_q     <= '0;
      rdy_q      <= 1'b0;
      do_q       <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      coll_q     <= 1'b0;
      aerr_q     <= 1'b0;
    end else begin
      if (accept) hold_q <= (!I_drpwe && in_range) ? mem_q[idx] : 16'h0000;
      rdy_q      <= done;
      do_q       <= done ? hold_q : 16'h0000;
      wr_pulse_q <= commit;
      if (commit) begin
        wr_addr_q <= I_drpaddr;
        wr_data_q <= I_drpdi;
      end
      coll_q <= collide;
      aerr_q <= accept && !in_range;
    end
  end

  assign O_drprdy    = rdy_q;
  assign O_drpdo     = do_q;
  assign O_wr_pulse  = wr_pulse_q;
  assign O_wr_addr   = wr_addr_q;
  assign O_wr_data   = wr_data_q;
  assign O_collision = coll_q;
  assign O_addr_err  = aerr_q;
endmodule
